stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Sequencing controller for the stopwatch timekeeping datapath. It consumes the single-cycle tick pulses from the clock divider (1 Hz, 2 Hz, blink) and owns the MM:SS BCD time registers. It arbitrates the run, pause and adjust modes and generates the per-digit blank mask for the display driver. It sits between the clock divider and debouncers upstream and the seven-segment mux downstream.

Parameters:
SEC_MAX, 59, terminal value of the seconds field (BCD 5,9), wraps to 00
MIN_MAX, 59, terminal value of the minutes field, wraps to 00

Ports:
sys_clk  in  1  system clock; all ticks are single-cycle enables in this domain
rst  in  1  asynchronous active-high reset
onehz_tick  in  1  1-cycle pulse, once per second
twohz_tick  in  1  1-cycle pulse, twice per second
blink_tick  in  1  1-cycle pulse; toggles blink phase
pause_pulse  in  1  debounced 1-cycle pause/resume request
adj_sw  in  1  level; 1 = adjust mode
sel_sw  in  1  level; 0 = adjust minutes, 1 = adjust seconds
min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD time digits
blank  out  4  per-digit blank mask [3]=min_tens .. [0]=sec_ones; 1 = digit off
mode  out  2  current state encoding (RUN=0, PAUSE=1, ADJ=2)

Behaviour:
- Reset (async, rst=1): all digits 0, blank=0000, mode=RUN, paused flag=0, blink phase=0. Outputs hold these values while rst is high.
- State machine (registered): RUN, PAUSE, ADJ. A separate paused flag records the run/pause intent.
- pause_pulse toggles the paused flag in every state.
- RUN -> PAUSE when the flag becomes 1.
- PAUSE -> RUN when the flag becomes 0.
- RUN/PAUSE -> ADJ when adj_sw=1, with priority over the pause transition in the same cycle.
- ADJ -> RUN if the paused flag is 0 when adj_sw=0, else ADJ -> PAUSE.
- Transitions take effect on the next sys_clk edge. Tick handling in any cycle uses the registered state at the start of that cycle.
- RUN: on onehz_tick, seconds += 1. At SEC_MAX, seconds -> 00 and minutes += 1 in the same cycle. At MIN_MAX:SEC_MAX the time wraps to 00:00.
- PAUSE: ticks ignored; digits held.
- ADJ: onehz_tick ignored. On twohz_tick, the field chosen by sel_sw increments by 1 and wraps at its max with no carry into the other field. The unselected field is held.
- sel_sw is sampled every cycle. A change takes effect on the next twohz_tick.
- BCD arithmetic: the ones digit 9 -> 0 carries into the tens digit. Digits never leave 0-9, and tens digits never exceed the max's tens digit.
- Blink phase toggles on every blink_tick in all states. It is cleared on entry to ADJ so the display starts visible.
- blank: in ADJ with phase=1, the selected pair is 11 (sel_sw=0 -> 1100, sel_sw=1 -> 0011). Otherwise blank=0000.
- blank and mode are registered, so they lag the cycle that changes state by one clock.
- Simultaneous events:
  - pause_pulse together with onehz_tick while in RUN: the tick is counted, pause applies next cycle.
  - onehz_tick together with twohz_tick in ADJ: only the 2 Hz increment occurs.
- Latency: a digit update is visible one sys_clk after the qualifying tick.
- rst asserted mid-operation clears everything immediately, regardless of state.

Decomposition:
- Package stopwatch_pkg: state enum encoding (RUN/PAUSE/ADJ), the BCD digit width constant 4, and the blank mask constants BLANK_MIN=1100 and BLANK_SEC=0011.
- Sub-module bcd2_counter: two-digit BCD counter.
  - Inputs: inc, parameterised max.
  - Outputs: tens, ones, carry_out (high when inc occurs at max).
  - Instantiated twice, seconds and minutes. The minutes inc = seconds carry_out in RUN, or the adjust increment in ADJ.

Test Plan:
1. Release rst, 61 onehz_ticks in RUN -> digits 01:01, blank=0000, mode=0.
2. Preset 59:58 by ticking, then 2 onehz_ticks -> 59:59 then 00:00. No digit is ever outside 0-9.
3. At 00:10, pause_pulse then 5 onehz_ticks -> mode=1, time stays 00:10. A second pause_pulse plus 1 tick -> mode=0, time 00:11.
4. adj_sw=1, sel_sw=1 at 00:58, 3 twohz_ticks -> 00:01 with minutes unchanged (no carry). blank toggles between 0011 and 0000 on blink_ticks.
5. adj_sw=1, sel_sw=0, 1 onehz_tick + 1 twohz_tick in the same cycle -> minutes +1, seconds unchanged. On adj_sw=0 -> mode=0 (paused flag 0), blank=0000.
6. Assert rst asynchronously, between clock edges, while in ADJ at 12:34 -> outputs go to 00:00, blank=0000, mode=0 before the next sys_clk edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch sequencing controller.
package stopwatch_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned MODE_W  = 2;
  localparam int unsigned BLANK_W = 4;

  // Controller states; the encoding is exported directly on the mode port.
  typedef enum logic [MODE_W-1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_ADJ   = 2'd2
  } state_e;

  // Blank masks, bit 3 = min_tens .. bit 0 = sec_ones; 1 turns a digit off.
  localparam logic [BLANK_W-1:0] BLANK_NONE = 4'b0000;
  localparam logic [BLANK_W-1:0] BLANK_MIN  = 4'b1100;
  localparam logic [BLANK_W-1:0] BLANK_SEC  = 4'b0011;

endpackage

// File: rtl/stopwatch_ctrl_bcd2_counter.sv
// Two-digit BCD counter that wraps to 00 after MAX and flags the wrap.
module bcd2_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX = 59
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc_i,
  output logic [DIGIT_W-1:0] tens_o,
  output logic [DIGIT_W-1:0] ones_o,
  output logic               carry_c
);

  localparam int unsigned MAX_TENS = MAX / 10;
  localparam int unsigned MAX_ONES = MAX % 10;

  logic [DIGIT_W-1:0] tens_q, tens_d;
  logic [DIGIT_W-1:0] ones_q, ones_d;
  logic               at_max_c;

  assign at_max_c = (tens_q == DIGIT_W'(MAX_TENS)) && (ones_q == DIGIT_W'(MAX_ONES));
  assign carry_c  = inc_i & at_max_c;

  // Next count: wrap at MAX, otherwise decimal increment with ones->tens carry.
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (inc_i) begin
      if (at_max_c) begin
        tens_d = '0;
        ones_d = '0;
      end else if (ones_q == DIGIT_W'(9)) begin
        ones_d = '0;
        tens_d = tens_q + DIGIT_W'(1);
      end else begin
        ones_d = ones_q + DIGIT_W'(1);
      end
    end
  end

  // Digit registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens_o = tens_q;
  assign ones_o = ones_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: run/pause/adjust arbitration, MM:SS BCD time and blink mask.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned SEC_MAX = 59,
  parameter int unsigned MIN_MAX = 59
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               onehz_tick,
  input  logic               twohz_tick,
  input  logic               blink_tick,
  input  logic               pause_pulse,
  input  logic               adj_sw,
  input  logic               sel_sw,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic [BLANK_W-1:0] blank,
  output logic [MODE_W-1:0]  mode
);

  state_e             state_q, state_d;
  logic               paused_q, paused_d;
  logic               phase_q, phase_d;
  logic [BLANK_W-1:0] blank_q, blank_d;

  logic               sec_inc_c;
  logic               min_inc_c;
  logic               sec_carry_c;
  logic               min_carry_unused;

  // Counter enables are qualified by the state held at the start of the cycle.
  assign sec_inc_c = ((state_q == ST_RUN) & onehz_tick) |
                     ((state_q == ST_ADJ) & twohz_tick & sel_sw);
  assign min_inc_c = ((state_q == ST_RUN) & sec_carry_c) |
                     ((state_q == ST_ADJ) & twohz_tick & ~sel_sw);

  // Mode arbitration, pause intent, blink phase and blank mask.
  always_comb begin
    state_d  = state_q;
    paused_d = paused_q ^ pause_pulse;
    phase_d  = phase_q ^ blink_tick;
    blank_d  = BLANK_NONE;

    case (state_q)
      ST_RUN: begin
        if (adj_sw)        state_d = ST_ADJ;
        else if (paused_d) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (adj_sw)         state_d = ST_ADJ;
        else if (!paused_d) state_d = ST_RUN;
      end
      ST_ADJ: begin
        if (!adj_sw) state_d = paused_d ? ST_PAUSE : ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    // Entering adjust restarts the blink so the digits start visible.
    if ((state_q != ST_ADJ) && (state_d == ST_ADJ)) phase_d = 1'b0;

    if ((state_d == ST_ADJ) && phase_d) blank_d = sel_sw ? BLANK_SEC : BLANK_MIN;
  end

  // Control registers.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      paused_q <= 1'b0;
      phase_q  <= 1'b0;
      blank_q  <= BLANK_NONE;
    end else begin
      state_q  <= state_d;
      paused_q <= paused_d;
      phase_q  <= phase_d;
      blank_q  <= blank_d;
    end
  end

  bcd2_counter #(.MAX(SEC_MAX)) u_sec (
    .clk     (sys_clk),
    .rst     (rst),
    .inc_i   (sec_inc_c),
    .tens_o  (sec_tens),
    .ones_o  (sec_ones),
    .carry_c (sec_carry_c)
  );

  // Minutes wrap on their own at MIN_MAX; their carry has no consumer.
  bcd2_counter #(.MAX(MIN_MAX)) u_min (
    .clk     (sys_clk),
    .rst     (rst),
    .inc_i   (min_inc_c),
    .tens_o  (min_tens),
    .ones_o  (min_ones),
    .carry_c (min_carry_unused)
  );

  assign blank = blank_q;
  assign mode  = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random traffic against a time/mode model.
module tb_stopwatch_ctrl;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       onehz_tick = 1'b0;
  logic       twohz_tick = 1'b0;
  logic       blink_tick = 1'b0;
  logic       pause_pulse = 1'b0;
  logic       adj_sw = 1'b0;
  logic       sel_sw = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [3:0] blank;
  logic [1:0] mode;

  stopwatch_ctrl dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .onehz_tick  (onehz_tick),
    .twohz_tick  (twohz_tick),
    .blink_tick  (blink_tick),
    .pause_pulse (pause_pulse),
    .adj_sw      (adj_sw),
    .sel_sw      (sel_sw),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .blank       (blank),
    .mode        (mode)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int failures = 0;

  // Reference model: time as plain minute/second integers, mode 0=run 1=pause 2=adjust.
  int         m_min, m_sec, m_mode;
  bit         m_paused, m_phase;
  logic [3:0] m_blank;

  logic [15:0] dut_time;
  assign dut_time = {min_tens, min_ones, sec_tens, sec_ones};

  function automatic logic [15:0] exp_time();
    return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
  endfunction

  task automatic model_reset();
    m_min = 0; m_sec = 0; m_mode = 0;
    m_paused = 0; m_phase = 0; m_blank = 4'b0000;
  endtask

  // Advance the model by one clock with the given pulses and current switches.
  task automatic model_clock(input bit one, input bit two, input bit blink, input bit pause);
    int total;
    int nm;
    bit np;
    if (m_mode == 0 && one) begin
      total = (m_min * 60 + m_sec + 1) % 3600;
      m_min = total / 60;
      m_sec = total % 60;
    end else if (m_mode == 2 && two) begin
      if (sel_sw) m_sec = (m_sec + 1) % 60;
      else        m_min = (m_min + 1) % 60;
    end
    np = m_paused ^ pause;
    nm = adj_sw ? 2 : (np ? 1 : 0);
    m_phase = (nm == 2 && m_mode != 2) ? 1'b0 : (m_phase ^ blink);
    m_blank = (nm == 2 && m_phase) ? (sel_sw ? 4'b0011 : 4'b1100) : 4'b0000;
    m_paused = np;
    m_mode = nm;
  endtask

  // Drive one cycle of pulses; returns 1 time unit after the active edge.
  task automatic step(input bit one, input bit two, input bit blink, input bit pause);
    onehz_tick = one; twohz_tick = two; blink_tick = blink; pause_pulse = pause;
    model_clock(one, two, blink, pause);
    @(posedge sys_clk);
    #1;
    onehz_tick = 0; twohz_tick = 0; blink_tick = 0; pause_pulse = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (dut_time !== 16'h0000) begin
      failures++; $display("FAIL reset_time_early got=%h exp=0000", dut_time);
    end
    repeat (3) @(posedge sys_clk);
    #1;
    checks++;
    if (dut_time !== 16'h0000) begin
      failures++; $display("FAIL reset_time got=%h exp=0000", dut_time);
    end
    checks++;
    if (blank !== 4'b0000) begin
      failures++; $display("FAIL reset_blank got=%b exp=0000", blank);
    end
    checks++;
    if (mode !== 2'd0) begin
      failures++; $display("FAIL reset_mode got=%0d exp=0", mode);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_run_count();
    for (int i = 0; i < 61; i++) begin
      repeat ($urandom_range(0, 2)) step(0, 0, 1'($urandom % 2), 0);
      step(1, 0, 1'($urandom % 2), 0);
      checks++;
      if (dut_time !== exp_time()) begin
        failures++; $display("FAIL run_tick%0d got=%h exp=%h", i, dut_time, exp_time());
      end
    end
    checks++;
    if (dut_time !== 16'h0101) begin
      failures++; $display("FAIL run_61 got=%h exp=0101", dut_time);
    end
    checks++;
    if (blank !== 4'b0000) begin
      failures++; $display("FAIL run_blank got=%b exp=0000", blank);
    end
    checks++;
    if (mode !== 2'd0) begin
      failures++; $display("FAIL run_mode got=%0d exp=0", mode);
    end
  endtask

  task automatic test_wrap();
    int bad;
    bad = 0;
    while (!(m_min == 59 && m_sec == 58)) begin
      step(1, 0, 0, 0);
      if (min_tens > 4'd5 || min_ones > 4'd9 || sec_tens > 4'd5 || sec_ones > 4'd9 ||
          dut_time !== exp_time()) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL wrap_walk bad_cycles=%0d exp=0", bad);
    end
    checks++;
    if (dut_time !== 16'h5958) begin
      failures++; $display("FAIL wrap_5958 got=%h exp=5958", dut_time);
    end
    step(1, 0, 0, 0);
    checks++;
    if (dut_time !== 16'h5959) begin
      failures++; $display("FAIL wrap_5959 got=%h exp=5959", dut_time);
    end
    step(1, 0, 0, 0);
    checks++;
    if (dut_time !== 16'h0000) begin
      failures++; $display("FAIL wrap_0000 got=%h exp=0000", dut_time);
    end
  endtask

  task automatic test_pause();
    while (!(m_min == 0 && m_sec == 10)) step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    checks++;
    if (mode !== 2'd1) begin
      failures++; $display("FAIL pause_mode got=%0d exp=1", mode);
    end
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 2)) step(0, 1'($urandom % 2), 0, 0);
      step(1, 0, 0, 0);
    end
    checks++;
    if (dut_time !== 16'h0010) begin
      failures++; $display("FAIL pause_hold got=%h exp=0010", dut_time);
    end
    step(0, 0, 0, 1);
    checks++;
    if (mode !== 2'd0) begin
      failures++; $display("FAIL resume_mode got=%0d exp=0", mode);
    end
    step(1, 0, 0, 0);
    checks++;
    if (dut_time !== 16'h0011) begin
      failures++; $display("FAIL resume_time got=%h exp=0011", dut_time);
    end
  endtask

  task automatic test_adj_sec();
    while (!(m_min == 0 && m_sec == 58)) step(1, 0, 0, 0);
    adj_sw = 1'b1; sel_sw = 1'b1;
    step(0, 0, 0, 0);
    checks++;
    if (mode !== 2'd2) begin
      failures++; $display("FAIL adj_mode got=%0d exp=2", mode);
    end
    checks++;
    if (blank !== 4'b0000) begin
      failures++; $display("FAIL adj_entry_blank got=%b exp=0000", blank);
    end
    for (int i = 0; i < 3; i++) step(1'($urandom % 2), 1, 0, 0);
    checks++;
    if (dut_time !== 16'h0001) begin
      failures++; $display("FAIL adj_sec_wrap got=%h exp=0001", dut_time);
    end
    step(0, 0, 1, 0);
    checks++;
    if (blank !== 4'b0011) begin
      failures++; $display("FAIL adj_blink_on got=%b exp=0011", blank);
    end
    step(0, 0, 1, 0);
    checks++;
    if (blank !== 4'b0000) begin
      failures++; $display("FAIL adj_blink_off got=%b exp=0000", blank);
    end
    step(0, 0, 1, 0);
    checks++;
    if (blank !== 4'b0011) begin
      failures++; $display("FAIL adj_blink_on2 got=%b exp=0011", blank);
    end
  endtask

  task automatic test_adj_min_simul();
    sel_sw = 1'b0;
    step(0, 0, 0, 0);
    checks++;
    if (blank !== 4'b1100) begin
      failures++; $display("FAIL adj_min_blank got=%b exp=1100", blank);
    end
    step(1, 1, 0, 0);
    checks++;
    if (dut_time !== 16'h0101) begin
      failures++; $display("FAIL adj_simul got=%h exp=0101", dut_time);
    end
    adj_sw = 1'b0;
    step(0, 0, 0, 0);
    checks++;
    if (mode !== 2'd0) begin
      failures++; $display("FAIL adj_exit_mode got=%0d exp=0", mode);
    end
    checks++;
    if (blank !== 4'b0000) begin
      failures++; $display("FAIL adj_exit_blank got=%b exp=0000", blank);
    end
  endtask

  task automatic test_back_to_back();
    step(1, 0, 0, 1);
    checks++;
    if (dut_time !== exp_time() || mode !== 2'd1) begin
      failures++; $display("FAIL b2b_pause_tick got=%h/%0d exp=%h/1", dut_time, mode, exp_time());
    end
    step(0, 0, 0, 1);
    adj_sw = 1'b1;
    step(0, 0, 0, 1);
    adj_sw = 1'b0;
    step(0, 0, 0, 0);
    checks++;
    if (mode !== 2'd1) begin
      failures++; $display("FAIL b2b_adj_to_pause got=%0d exp=1", mode);
    end
    step(0, 0, 0, 1);
    checks++;
    if (mode !== 2'd0) begin
      failures++; $display("FAIL b2b_resume got=%0d exp=0", mode);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 50 == 0) adj_sw = ~adj_sw;
      if ($urandom % 10 == 0) sel_sw = ~sel_sw;
      step(1'($urandom % 3 == 0), 1'($urandom % 3 == 0), 1'($urandom % 4 == 0),
           1'($urandom % 20 == 0));
      checks++;
      if (dut_time !== exp_time() || blank !== m_blank || mode !== 2'(m_mode)) begin
        failures++; bad++;
        if (bad <= 5)
          $display("FAIL random_cyc%0d got=%h/%b/%0d exp=%h/%b/%0d", i, dut_time, blank, mode,
                   exp_time(), m_blank, m_mode);
      end
    end
  endtask

  task automatic test_async_reset();
    int guard;
    adj_sw = 1'b1; sel_sw = 1'b0;
    guard = 0;
    while ((m_min != 12 || m_mode != 2) && guard < 200) begin step(0, 1, 0, 0); guard++; end
    sel_sw = 1'b1;
    while (m_sec != 34 && guard < 400) begin step(0, 1, 0, 0); guard++; end
    checks++;
    if (dut_time !== 16'h1234 || mode !== 2'd2) begin
      failures++; $display("FAIL areset_setup got=%h/%0d exp=1234/2", dut_time, mode);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (dut_time !== 16'h0000 || blank !== 4'b0000 || mode !== 2'd0) begin
      failures++; $display("FAIL areset_immediate got=%h/%b/%0d exp=0000/0000/0", dut_time, blank, mode);
    end
    step(1, 1, 1, 1);
    checks++;
    if (dut_time !== 16'h0000 || blank !== 4'b0000 || mode !== 2'd0) begin
      failures++; $display("FAIL areset_hold got=%h/%b/%0d exp=0000/0000/0", dut_time, blank, mode);
    end
    adj_sw = 1'b0;
    rst = 1'b0;
    model_reset();
    step(1, 0, 0, 0);
    checks++;
    if (dut_time !== 16'h0001) begin
      failures++; $display("FAIL areset_restart got=%h exp=0001", dut_time);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_run_count();
    test_wrap();
    test_pause();
    test_adj_sec();
    test_adj_min_simul();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
